// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the core-to-Wishbone master bridge: load/store width codes and
// the bridge FSM state type.
package wb_bridge_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } bridge_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte selects, replicated store data, alignment check and
// sign/zero extension of the addressed load lane.
module mem_lane_align
    import wb_bridge_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    output logic [31:0] o_rdata_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_sel        = 4'b0000;
        o_wdata      = 32'h0;
        o_misaligned = 1'b0;
        o_rdata_ext  = 32'h0;
        case (i_op)
            OP_B, OP_BU: begin
                o_sel       = 4'b0001 << i_off;
                o_wdata     = {4{i_wdata[7:0]}};
                o_rdata_ext = (i_op == OP_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            end
            OP_H, OP_HU: begin
                o_misaligned = i_off[0];
                o_sel        = 4'b0011 << i_off;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata_ext  = (i_op == OP_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            end
            OP_W: begin
                o_misaligned = (i_off != 2'b00);
                o_sel        = 4'hF;
                o_wdata      = i_wdata;
                o_rdata_ext  = i_rdata;
            end
            // Reserved width codes never reach the bus.
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_master_bridge.sv
// Single-access Wishbone classic master for the memory stage: one bus cycle per request,
// pipeline stalled until termination, misalignment and ack-timeout reported via bus_err.
module wb_master_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  mem_op,
    output logic [31:0] mem_rdata,
    output logic        stall_pipl,
    output logic        bus_err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t    r_state, w_state_next;
    logic             r_cyc, w_cyc_next;
    logic             r_stb, w_stb_next;
    logic             r_we, w_we_next;
    logic [31:0]      r_adr, w_adr_next;
    logic [31:0]      r_dat, w_dat_next;
    logic [3:0]       r_sel, w_sel_next;
    logic [31:0]      r_rdata, w_rdata_next;
    logic             r_bus_err, w_bus_err_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_op, w_op_next;
    logic [1:0]       r_off, w_off_next;

    logic        w_req;
    logic        w_stall;
    logic [2:0]  w_align_op;
    logic [1:0]  w_align_off;
    logic [3:0]  w_lane_sel;
    logic [31:0] w_lane_wdata;
    logic        w_misaligned;
    logic [31:0] w_lane_rdata;

    assign w_req = mem_read | mem_write;

    // Live request fields decide the lanes in IDLE; the latched copy drives load extension in BUS.
    assign w_align_op  = (r_state == IDLE) ? mem_op : r_op;
    assign w_align_off = (r_state == IDLE) ? mem_addr[1:0] : r_off;

    mem_lane_align u_lane_align (
        .i_op         (w_align_op),
        .i_off        (w_align_off),
        .i_wdata      (mem_wdata),
        .i_rdata      (wb_dat_i),
        .o_sel        (w_lane_sel),
        .o_wdata      (w_lane_wdata),
        .o_misaligned (w_misaligned),
        .o_rdata_ext  (w_lane_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= 32'h0;
            r_dat     <= 32'h0;
            r_sel     <= 4'h0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b0;
            r_cnt     <= '0;
            r_op      <= 3'b000;
            r_off     <= 2'b00;
        end else begin
            r_state   <= w_state_next;
            r_cyc     <= w_cyc_next;
            r_stb     <= w_stb_next;
            r_we      <= w_we_next;
            r_adr     <= w_adr_next;
            r_dat     <= w_dat_next;
            r_sel     <= w_sel_next;
            r_rdata   <= w_rdata_next;
            r_bus_err <= w_bus_err_next;
            r_cnt     <= w_cnt_next;
            r_op      <= w_op_next;
            r_off     <= w_off_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cyc_next     = r_cyc;
        w_stb_next     = r_stb;
        w_we_next      = r_we;
        w_adr_next     = r_adr;
        w_dat_next     = r_dat;
        w_sel_next     = r_sel;
        w_rdata_next   = r_rdata;
        w_bus_err_next = r_bus_err;
        w_cnt_next     = r_cnt;
        w_op_next      = r_op;
        w_off_next     = r_off;
        w_stall        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall    = 1'b1;
                    w_cnt_next = '0;
                    if (w_misaligned) begin
                        w_rdata_next   = 32'h0;
                        w_bus_err_next = 1'b1;
                        w_state_next   = DONE;
                    end else begin
                        w_adr_next   = {mem_addr[31:2], 2'b00};
                        w_dat_next   = mem_write ? w_lane_wdata : 32'h0;
                        w_sel_next   = w_lane_sel;
                        w_we_next    = mem_write;
                        w_cyc_next   = 1'b1;
                        w_stb_next   = 1'b1;
                        w_op_next    = mem_op;
                        w_off_next   = mem_addr[1:0];
                        w_state_next = BUS;
                    end
                end
            end
            BUS: begin
                w_stall    = 1'b1;
                w_cnt_next = r_cnt + CNT_W'(1);
                if (wb_err_i || wb_ack_i || (r_cnt == CNT_LAST)) begin
                    w_cyc_next   = 1'b0;
                    w_stb_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_state_next = DONE;
                    // err_i outranks ack_i; reaching the last counted cycle without ack is a timeout.
                    if (wb_err_i || !wb_ack_i) begin
                        w_rdata_next   = 32'h0;
                        w_bus_err_next = 1'b1;
                    end else begin
                        w_rdata_next = r_we ? 32'h0 : w_lane_rdata;
                    end
                end
            end
            DONE: begin
                w_bus_err_next = 1'b0;
                w_cnt_next     = '0;
                w_state_next   = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Gated by reset so an in-flight request is released as soon as reset asserts.
    assign stall_pipl = reset_n & w_stall;
    assign mem_rdata  = r_rdata;
    assign bus_err    = r_bus_err;
    assign wb_adr_o   = r_adr;
    assign wb_dat_o   = r_dat;
    assign wb_sel_o   = r_sel;
    assign wb_we_o    = r_we;
    assign wb_cyc_o   = r_cyc;
    assign wb_stb_o   = r_stb;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: scripted Wishbone slave plus expectation queue.
module tb_wb_master_bridge;
    import wb_bridge_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] mem_rdata;
    logic        stall_pipl;
    logic        bus_err;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    always #5 clk = ~clk;

    wb_master_bridge #(
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_op     (mem_op),
        .mem_rdata  (mem_rdata),
        .stall_pipl (stall_pipl),
        .bus_err    (bus_err),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          cycs;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Slave script: mode 0 ack, 1 err, 2 silent, 3 err+ack; responds after slv_wait cycles.
    int          slv_wait = 0;
    int          slv_mode = 0;
    logic [31:0] slv_data = 32'h0;
    int          slv_cnt = 0;
    int          cyc_total = 0;
    logic [31:0] cap_adr = 32'h0;
    logic [31:0] cap_dat = 32'h0;
    logic [3:0]  cap_sel = 4'h0;
    logic        cap_we = 1'b0;

    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o) begin
            if (slv_cnt == 0) begin
                cap_adr = wb_adr_o;
                cap_dat = wb_dat_o;
                cap_sel = wb_sel_o;
                cap_we  = wb_we_o;
            end
            wb_ack_i  = (slv_cnt >= slv_wait) && (slv_mode == 0 || slv_mode == 3);
            wb_err_i  = (slv_cnt >= slv_wait) && (slv_mode == 1 || slv_mode == 3);
            wb_dat_i  = slv_data;
            slv_cnt   = slv_cnt + 1;
            cyc_total = cyc_total + 1;
        end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            slv_cnt  = 0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = d[16*off[1] +: 16];
        case (op)
            OP_B:    return {{24{b[7]}}, b};
            OP_BU:   return {24'h0, b};
            OP_H:    return {{16{h[15]}}, h};
            OP_HU:   return {16'h0, h};
            default: return d;
        endcase
    endfunction

    task automatic run_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic wr, input logic rd, input logic [2:0] op,
                              input int wt, input int mode, input logic [31:0] sdata,
                              input logic [31:0] e_rdata, input logic e_err, input int e_stalls,
                              input int e_cycs, input logic [3:0] e_sel, input logic [31:0] e_dat);
        exp_t e;
        int   stalls;
        int   cyc0;
        e.rdata  = e_rdata;
        e.err    = e_err;
        e.stalls = e_stalls;
        e.cycs   = e_cycs;
        e.adr    = addr & 32'hFFFF_FFFC;
        e.sel    = e_sel;
        e.we     = wr;
        e.dat    = e_dat;
        sb_q.push_back(e);
        slv_wait = wt;
        slv_mode = mode;
        slv_data = sdata;
        @(negedge clk);
        cyc0      = cyc_total;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_write = wr;
        mem_read  = rd;
        mem_op    = op;
        #1;
        stalls = 0;
        while (stall_pipl && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        e = sb_q.pop_front();
        check_val({tag, "/stall"}, 32'(stalls), 32'(e.stalls));
        check_val({tag, "/cyc"}, 32'(cyc_total - cyc0), 32'(e.cycs));
        check_val({tag, "/rdata"}, mem_rdata, e.rdata);
        check_val({tag, "/err"}, {31'h0, bus_err}, {31'h0, e.err});
        if (e.cycs > 0) begin
            check_val({tag, "/adr"}, cap_adr, e.adr);
            check_val({tag, "/sel"}, {28'h0, cap_sel}, {28'h0, e.sel});
            check_val({tag, "/we"}, {31'h0, cap_we}, {31'h0, e.we});
            if (e.we) check_val({tag, "/dat"}, cap_dat, e.dat);
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(negedge clk);
        #1;
        check_val({tag, "/err_clr"}, {31'h0, bus_err}, 32'h0);
        check_val({tag, "/idle_stall"}, {31'h0, stall_pipl}, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        #12;
        check_val("rst/cyc", {31'h0, wb_cyc_o}, 32'h0);
        check_val("rst/stb", {31'h0, wb_stb_o}, 32'h0);
        check_val("rst/we", {31'h0, wb_we_o}, 32'h0);
        check_val("rst/adr", wb_adr_o, 32'h0);
        check_val("rst/dat", wb_dat_o, 32'h0);
        check_val("rst/sel", {28'h0, wb_sel_o}, 32'h0);
        check_val("rst/rdata", mem_rdata, 32'h0);
        check_val("rst/err", {31'h0, bus_err}, 32'h0);
        check_val("rst/stall", {31'h0, stall_pipl}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        run_access("sw", 32'h104, 32'hDEAD_BEEF, 1, 0, OP_W, 0, 0, 32'h0,
                   32'h0, 0, 2, 1, 4'hF, 32'hDEAD_BEEF);
        run_access("lb", 32'h103, 32'h0, 0, 1, OP_B, 3, 0, 32'h80FF_1234,
                   32'hFFFF_FF80, 0, 5, 4, 4'b1000, 32'h0);
        run_access("lw_mis", 32'h5, 32'h0, 0, 1, OP_W, 0, 0, 32'h0,
                   32'h0, 1, 1, 0, 4'h0, 32'h0);
        run_access("lhu", 32'h2, 32'h0, 0, 1, OP_HU, 0, 0, 32'hABCD_0000,
                   32'h0000_ABCD, 0, 2, 1, 4'b1100, 32'h0);
        run_access("sh", 32'h2, 32'h1234, 1, 0, OP_H, 1, 0, 32'h0,
                   32'h0, 0, 3, 2, 4'b1100, 32'h1234_1234);
        run_access("sb_rw", 32'h301, 32'h77A5, 1, 1, OP_B, 0, 0, 32'hFFFF_FFFF,
                   32'h0, 0, 2, 1, 4'b0010, 32'hA5A5_A5A5);
        run_access("lh_mis", 32'h1, 32'h0, 0, 1, OP_H, 0, 0, 32'h0,
                   32'h0, 1, 1, 0, 4'h0, 32'h0);
        run_access("op011", 32'h0, 32'h0, 0, 1, 3'b011, 0, 0, 32'h0,
                   32'h0, 1, 1, 0, 4'h0, 32'h0);

        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            run_access("lb_off", 32'h200 + i, 32'h0, 0, 1, OP_B, i, 0, d,
                       model_load(OP_B, 2'(i), d), 0, 2 + i, 1 + i, 4'b0001 << i, 32'h0);
            d = $urandom;
            run_access("lbu_off", 32'h200 + i, 32'h0, 0, 1, OP_BU, 0, 0, d,
                       model_load(OP_BU, 2'(i), d), 0, 2, 1, 4'b0001 << i, 32'h0);
        end
        for (int i = 0; i < 4; i += 2) begin
            d = $urandom;
            run_access("lh_off", 32'h400 + i, 32'h0, 0, 1, OP_H, 0, 0, d | 32'h8000_8000,
                       model_load(OP_H, 2'(i), d | 32'h8000_8000), 0, 2, 1, 4'b0011 << i,
                       32'h0);
        end

        run_access("lw_err", 32'h20, 32'h0, 0, 1, OP_W, 0, 1, 32'h1234_5678,
                   32'h0, 1, 2, 1, 4'hF, 32'h0);
        run_access("lw_errack", 32'h20, 32'h0, 0, 1, OP_W, 1, 3, 32'h1234_5678,
                   32'h0, 1, 3, 2, 4'hF, 32'h0);
        run_access("sw_tmo", 32'h40, 32'h5555_AAAA, 1, 0, OP_W, 0, 2, 32'h0,
                   32'h0, 1, 5, 4, 4'hF, 32'h5555_AAAA);

        // Reset in the middle of a bus cycle that the slave never answers.
        slv_mode = 2;
        @(negedge clk);
        mem_addr = 32'h10;
        mem_op   = OP_W;
        mem_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("mid/cyc_before", {31'h0, wb_cyc_o}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("mid/cyc", {31'h0, wb_cyc_o}, 32'h0);
        check_val("mid/stb", {31'h0, wb_stb_o}, 32'h0);
        check_val("mid/stall", {31'h0, stall_pipl}, 32'h0);
        check_val("mid/err", {31'h0, bus_err}, 32'h0);
        mem_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_val("mid/err_after", {31'h0, bus_err}, 32'h0);
        run_access("lw_post", 32'h10, 32'h0, 0, 1, OP_W, 1, 0, 32'h1122_3344,
                   32'h1122_3344, 0, 3, 2, 4'hF, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Bridges the core's memory-stage load/store bus onto a Wishbone classic (B3, non-pipelined) master port feeding wb_intercon.
- Per access it generates byte-lane selects and aligned write data, runs one single Wishbone cycle, and sign/zero-extends read data back to the core.
- Holds the pipeline via stall_pipl until the cycle terminates.
- Adds misalignment detection and an ack timeout so a dead slave cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUS awaiting ack/err before forced error termination; must be ≥1, counter width $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mem_addr  in  32  byte address from mem stage
- mem_wdata  in  32  store data, right-justified
- mem_write  in  1  store request
- mem_read  in  1  load request
- mem_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_rdata  out  32  extended load result
- stall_pipl  out  1  hold pipeline
- bus_err  out  1  one-cycle pulse: misaligned, err_i or timeout
- wb_adr_o  out  32  {mem_addr[31:2],2'b00}
- wb_dat_o  out  32  lane-positioned write data
- wb_sel_o  out  4  byte enables
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  slave error

Behaviour:
- Reset (async, reset_n=0): state IDLE; all wb_* outputs, mem_rdata, bus_err and the timeout counter go to 0. stall_pipl is combinational: 0 in IDLE with no request.
- req = mem_read | mem_write. Both high is treated as a write.
- States: IDLE, BUS, DONE.
- IDLE, req=0: stall_pipl=0.
- IDLE, req=1: stall_pipl=1 combinationally.
  - Aligned: register adr/dat/sel/we, set cyc=stb=1, next state BUS.
  - Misaligned (H with addr[0]=1, W with addr[1:0]≠0, or unused mem_op 011/11x): no bus cycle; mem_rdata←0, bus_err←1, next state DONE.
- BUS: stall_pipl=1; cyc/stb/adr/dat/sel/we held stable; counter increments each cycle.
  - ack_i: mem_rdata←extended wb_dat_i (0 for writes), cyc=stb=we=0, next state DONE.
  - err_i (priority over ack): mem_rdata←0, bus_err←1, next state DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack/err: same as err_i.
- DONE: stall_pipl=0 for exactly one cycle; mem_rdata valid; bus_err cleared on exit; counter cleared; next state IDLE unconditionally. Back-to-back identical requests therefore start fresh cycles.
- Minimum latency: request cycle + one BUS cycle with same-cycle ack gives 2 stall cycles, and data valid in DONE.
- Store lanes (off = addr[1:0]):
  - SB: sel = 4'b0001<<off; dat = {4{wdata[7:0]}}.
  - SH: sel = 4'b0011<<off; dat = {2{wdata[15:0]}}.
  - SW: sel = 4'hF; dat = wdata.
- Load extract:
  - B/BU: byte dat_i[8*off +: 8], sign/zero-extended.
  - H/HU: half dat_i[16*off[1] +: 16], sign/zero-extended.
  - Loads drive sel per the same lane rules as stores.
- mem_rdata holds its value until the next termination. The core must keep mem_* stable while stall_pipl=1; no re-sampling occurs in BUS.
- A reset asserted mid-BUS drops cyc/stb immediately (async), with no completion and no bus_err.

Decomposition:
- Package wb_bridge_pkg: mem_op localparams (OP_B, OP_H, OP_W, OP_BU, OP_HU); state enum typedef bridge_state_t {IDLE, BUS, DONE}.
- Sub-module mem_lane_align (combinational): produces sel, write data, misaligned flag and load extension from mem_op/offset.

Test Plan:
- SW addr 0x0000_0104, wdata 0xDEADBEEF, ack on first BUS cycle → adr=0x104, sel=F, we=1, stall high 2 cycles, bus_err=0.
- LB addr 0x0000_0103, dat_i=0x80FF_1234, ack after 3 wait cycles → sel=1000, mem_rdata=0xFFFF_FF80 in DONE, stall high 5 cycles.
- LHU addr 0x0000_0002, dat_i=0xABCD_0000 → sel=1100, mem_rdata=0x0000_ABCD; SH addr 0x2, wdata 0x1234 → dat_o=0x1234_1234, sel=1100.
- LW addr 0x0000_0005 → no cyc asserted, bus_err pulse 1 cycle, mem_rdata=0, stall high 1 cycle.
- TIMEOUT_CYCLES=4, slave never acks → cyc drops after 4 BUS cycles, bus_err=1 in DONE; err_i asserted with ack_i in the same cycle → error path wins.
- reset_n low mid-BUS → cyc/stb/stall 0 asynchronously; after release, a fresh LW to 0x10 completes normally.
